// File: rtl/mul_seq_param.sv
`default_nettype none
// mul_seq_param: W-bit sequential shift-add multiplier with signed/unsigned mode,
// early termination on a zero multiplier remainder, and a start/ack handshake. Rev 1.0
module mul_seq_param #(
   parameter int W = 8
) (
   input  logic           Clk,
   input  logic           Rst_n,
   input  logic           start,
   input  logic           sgn,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   output logic [2*W-1:0] R,
   output logic           ack,
   output logic           busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]     state;
   logic [2*W-1:0] x;
   logic [W-1:0]   y;
   logic           neg;
   logic [W-1:0]   mag_a;
   logic [W-1:0]   mag_b;

   // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude.
   always_comb begin
      mag_a = (sgn && A[W-1]) ? -A : A;
      mag_b = (sgn && B[W-1]) ? -B : B;
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state <= ST_IDLE;
         R     <= '0;
         ack   <= 1'b0;
         x     <= '0;
         y     <= '0;
         neg   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  x     <= {{W{1'b0}}, mag_a};
                  y     <= mag_b;
                  neg   <= sgn & (A[W-1] ^ B[W-1]);
                  R     <= '0;
                  ack   <= 1'b0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (y == '0) begin
                  state <= ST_FIX;
               end else begin
                  if (y[0]) begin
                     R <= R + x;
                  end
                  x <= x << 1;
                  y <= y >> 1;
               end
            end
            ST_FIX: begin
               if (neg) begin
                  R <= -R;
               end
               ack   <= 1'b1;
               state <= ST_DONE;
            end
            ST_DONE: begin
               ack   <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
